osg_pulse_sequencer: RTL and testbench
======================================

// Module: osg_pulse_sequencer
// PURPOSE
// - Sequences the OSG light-pulse enable. Accepts start requests from the front-panel
//   button (active-low, debounced) and the PC link, and drives one timed pulse.
// - Arbitrates the two requesters and enforces a programmable pulse length and a
//   hard max-duration watchdog. Honours external end_flg and abort.
// - Enforces a holdoff before re-arm. Sits between the user/PC inputs and the optical
//   driver enable.
// PARAMETERS
// CNT_W      32        width of pulse/holdoff counters and length inputs
// DEB_CYC    500000    button debounce stable-time in sq_clk cycles (10 ms @ 50 MHz)
// MAX_LEN    50000000  watchdog: absolute max pulse_o high time in cycles (1 s @ 50 MHz)
// PORTS
// sq_clk       in   1      single system clock
// sq_rst       in   1      asynchronous, active-high reset
// btn_n        in   1      raw start button, active-low, asynchronous
// pc_start     in   1      PC start request, level, synchronous; rising edge = request
// end_flg      in   1      external end-of-measurement, ends pulse/burst
// abort        in   1      immediate stop, any state
// pulse_len    in   CNT_W  requested pulse length (cycles), latched at start
// hold_len     in   CNT_W  holdoff/gap length (cycles), latched at start
// burst_n      in   8      pulses per burst (only with OSG_BURST_EN)
// pulse_o      out  1      light-pulse enable
// busy         out  1      high in any state except IDLE
// done         out  1      one-cycle strobe when sequence completes normally
// timeout      out  1      sticky: watchdog fired; cleared by next accepted start
// src          out  1      requester of current/last sequence: 0 button, 1 PC
// BEHAVIOUR
// - Reset: all outputs 0, state IDLE, counters 0, debouncer output = released.
// - Button: 2-FF synchroniser, then debounce; request = debounced falling edge.
// - PC: request = pc_start sampled 1 with previous sample 0.
// - Same-cycle button+PC request: PC wins, src=1; button request is dropped.
// - Requests outside IDLE are ignored, never queued.
// - FSM IDLE -> RUN -> HOLD -> IDLE.
//   - IDLE: on request, latch pulse_len/hold_len (pulse_len==0 -> MAX_LEN), set src,
//     clear timeout. pulse_o=1 on the same edge that detects the request.
//   - RUN: pulse_o high exactly L cycles, L = min(latched len, MAX_LEN).
//     - end_flg sampled 1: pulse_o=0 on that edge, -> HOLD.
//     - Watchdog expiry before L: timeout=1, -> HOLD.
//     - end_flg and expiry in the same cycle: end_flg wins, no timeout.
//   - HOLD: hold_len cycles, busy=1, pulse_o=0. Exit -> IDLE; done=1 on the exit edge
//     unless the RUN ended by watchdog (then done=0). hold_len==0 -> one-cycle HOLD.
// - abort: on next edge pulse_o=0, -> IDLE, no done, timeout unchanged.
//   abort beats end_flg and a request in the same cycle.
// - sq_rst mid-pulse: pulse_o drops asynchronously.
// - Counters are CNT_W unsigned, saturate, never wrap.
// CONFIGURATION
// - OSG_BURST_EN defined: burst_n input present, latched at start (0 treated as 1).
//   - After each pulse, HOLD acts as the inter-pulse gap; then re-enter RUN until
//     burst_n pulses are done. Final HOLD -> IDLE with done.
//   - end_flg or timeout ends the whole burst (finish current HOLD, then IDLE).
// - Undefined: no burst_n port; single pulse per request, behaviour as above.
// STRUCTURE
// - Package osg_pkg: state enum (IDLE/RUN/HOLD), SRC_BTN/SRC_PC constants, default
//   DEB_CYC/MAX_LEN.
// - Sub-module osg_debounce: synchroniser + DEB_CYC stable counter, outputs
//   debounced level. Falling-edge detect stays in the sequencer.
// TESTING
// - pc_start 0->1, pulse_len=10, hold_len=5 -> pulse_o high 10 cycles, busy 15,
//   done at exit, src=1.
// - btn_n low glitch < DEB_CYC -> no pulse. Held low > DEB_CYC -> pulse starts,
//   src=0.
// - Button and PC requests in the same cycle -> one pulse, src=1. Second
//   pc_start edge during RUN ignored.
// - pulse_len=0 with MAX_LEN=100 (test override) -> pulse_o 100 cycles,
//   timeout=1, done=0.
// - end_flg at pulse cycle 3 of 10 -> pulse_o falls that edge, holdoff runs, done=1.
//   abort in RUN -> IDLE next edge, no done.
// - OSG_BURST_EN, burst_n=3, len=4, hold=2 -> three 4-cycle pulses 2 apart,
//   one done. burst_n=0 -> single pulse.

Source files
------------

// File: rtl/osg_pkg.sv
// Shared types and defaults for the OSG light-pulse sequencer.
package osg_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } osg_state_e;

    localparam logic SRC_BTN = 1'b0;
    localparam logic SRC_PC  = 1'b1;

    localparam int unsigned DEB_CYC_DEF = 500000;    // 10 ms at 50 MHz
    localparam int unsigned MAX_LEN_DEF = 50000000;  // 1 s at 50 MHz

endpackage

// File: rtl/osg_debounce.sv
// Front-panel button conditioning: 2-FF synchroniser followed by a stable-time
// filter. The debounced level only follows the input after DEB_CYC steady cycles.
module osg_debounce
    import osg_pkg::*;
#(
    parameter int unsigned DEB_CYC = DEB_CYC_DEF
) (
    input  logic sq_clk,
    input  logic sq_rst,
    input  logic btn_n,
    output logic btn_deb
);

    localparam int unsigned DW = $clog2(DEB_CYC + 1);
    localparam logic [DW-1:0] DEB_LOAD = DW'(DEB_CYC);

    logic [1:0]    sync_q;
    logic          deb_q;
    logic [DW-1:0] cnt_q;

    // Released (high) is the safe idle level so reset never looks like a press.
    always_ff @(posedge sq_clk or posedge sq_rst) begin
        if (sq_rst) begin
            sync_q <= 2'b11;
            deb_q  <= 1'b1;
            cnt_q  <= '0;
        end else begin
            sync_q <= {sync_q[0], btn_n};
            if (sync_q[1] == deb_q) begin
                cnt_q <= DEB_LOAD;
            end else if (cnt_q <= DW'(1)) begin
                deb_q <= sync_q[1];
                cnt_q <= DEB_LOAD;
            end else begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    assign btn_deb = deb_q;

endmodule

// File: rtl/osg_pulse_sequencer.sv
// OSG light-pulse sequencer: arbitrates button/PC starts, times one pulse plus holdoff.
// Define OSG_BURST_EN to add the burst_n port and multi-pulse bursts.
//
// state | meaning
// IDLE  | waiting for a request, pulse_o low
// RUN   | pulse_o high, length and watchdog timers counting down
// HOLD  | holdoff (or inter-pulse gap in a burst), pulse_o low
module osg_pulse_sequencer
    import osg_pkg::*;
#(
    parameter int unsigned CNT_W   = 32,
    parameter int unsigned DEB_CYC = DEB_CYC_DEF,
    parameter int unsigned MAX_LEN = MAX_LEN_DEF
) (
    input  logic             sq_clk,
    input  logic             sq_rst,
    input  logic             btn_n,
    input  logic             pc_start,
    input  logic             end_flg,
    input  logic             abort,
    input  logic [CNT_W-1:0] pulse_len,
    input  logic [CNT_W-1:0] hold_len,
`ifdef OSG_BURST_EN
    input  logic [7:0]       burst_n,
`endif
    output logic             pulse_o,
    output logic             busy,
    output logic             done,
    output logic             timeout,
    output logic             src
);

    localparam logic [CNT_W-1:0] MAX_L = CNT_W'(MAX_LEN);

    osg_state_e       state_q, state_d;
    logic             btn_deb, btn_deb_q, pc_q;
    logic             btn_req, pc_req, start;
    logic             len_exp, wd_exp, hold_exp, more_pulses;
    logic [CNT_W-1:0] start_len, start_hold;
    logic [CNT_W-1:0] run_len_q, hold_q, len_cnt, wd_cnt, hold_cnt;
    logic             done_q, timeout_q, src_q;

    osg_debounce #(.DEB_CYC(DEB_CYC)) u_debounce (
        .sq_clk (sq_clk),
        .sq_rst (sq_rst),
        .btn_n  (btn_n),
        .btn_deb(btn_deb)
    );

    assign btn_req  = btn_deb_q & ~btn_deb;
    assign pc_req   = pc_start & ~pc_q;
    assign start    = (state_q == IDLE) && (btn_req || pc_req) && !abort;
    assign len_exp  = (len_cnt <= CNT_W'(1));
    assign wd_exp   = (wd_cnt <= CNT_W'(1));
    assign hold_exp = (hold_cnt <= CNT_W'(1));

    always_comb begin
        start_len = pulse_len;
        if (pulse_len == '0 || pulse_len > MAX_L) start_len = MAX_L;
        start_hold = (hold_len == '0) ? CNT_W'(1) : hold_len;
    end

`ifdef OSG_BURST_EN
    logic [7:0] burst_left;
    logic       stop_q;
    assign more_pulses = !stop_q && (burst_left != 8'd0);
`else
    assign more_pulses = 1'b0;
`endif

    always_ff @(posedge sq_clk or posedge sq_rst) begin
        if (sq_rst) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start) state_d = RUN;
            RUN: begin
                if (abort)                                state_d = IDLE;
                else if (end_flg || wd_exp || len_exp)    state_d = HOLD;
            end
            HOLD: begin
                if (abort)         state_d = IDLE;
                else if (hold_exp) state_d = more_pulses ? RUN : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // pulse_o decodes the state register, so it rises on the request edge and
    // falls with the async reset.
    always_comb begin
        pulse_o = (state_q == RUN);
        busy    = (state_q != IDLE);
        done    = done_q;
        timeout = timeout_q;
        src     = src_q;
    end

    always_ff @(posedge sq_clk or posedge sq_rst) begin
        if (sq_rst) begin
            btn_deb_q <= 1'b1;
            pc_q      <= 1'b0;
            run_len_q <= '0;
            hold_q    <= '0;
            len_cnt   <= '0;
            wd_cnt    <= '0;
            hold_cnt  <= '0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            src_q     <= SRC_BTN;
`ifdef OSG_BURST_EN
            burst_left <= 8'd0;
            stop_q     <= 1'b0;
`endif
        end else begin
            btn_deb_q <= btn_deb;
            pc_q      <= pc_start;
            done_q    <= 1'b0;
            if (start) begin
                run_len_q <= start_len;
                hold_q    <= start_hold;
                len_cnt   <= start_len;
                wd_cnt    <= MAX_L;
                src_q     <= pc_req ? SRC_PC : SRC_BTN;
                timeout_q <= 1'b0;
`ifdef OSG_BURST_EN
                burst_left <= (burst_n == 8'd0) ? 8'd0 : burst_n - 8'd1;
                stop_q     <= 1'b0;
`endif
            end else begin
                case (state_q)
                    RUN: begin
                        if (state_d == HOLD) begin
                            hold_cnt <= hold_q;
                            // end_flg in the expiry cycle counts as a normal end
                            if (wd_exp && !end_flg) timeout_q <= 1'b1;
`ifdef OSG_BURST_EN
                            stop_q <= end_flg || wd_exp;
`endif
                        end else begin
                            if (len_cnt != '0) len_cnt <= len_cnt - 1'b1;
                            if (wd_cnt != '0)  wd_cnt  <= wd_cnt - 1'b1;
                        end
                    end
                    HOLD: begin
                        if (state_d == RUN) begin
                            len_cnt <= run_len_q;
                            wd_cnt  <= MAX_L;
`ifdef OSG_BURST_EN
                            if (burst_left != 8'd0) burst_left <= burst_left - 8'd1;
`endif
                        end else begin
                            if (hold_cnt != '0) hold_cnt <= hold_cnt - 1'b1;
                            if (state_d == IDLE && !abort && !timeout_q) done_q <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_osg_pulse_sequencer.sv
// Scoreboard bench for osg_pulse_sequencer; honours OSG_BURST_EN when defined.
module tb_osg_pulse_sequencer;

    localparam int unsigned CNT_W = 32;
    localparam int unsigned DEB   = 8;
    localparam int unsigned MAXL  = 100;
`ifdef OSG_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    logic sq_clk = 1'b0;
    logic sq_rst = 1'b0;
    logic btn_n = 1'b1, pc_start = 1'b0, end_flg = 1'b0, abort = 1'b0;
    logic [CNT_W-1:0] pulse_len = '0, hold_len = '0;
`ifdef OSG_BURST_EN
    logic [7:0] burst_n = 8'd0;
`endif
    logic pulse_o, busy, done, timeout, src;

    always #5 sq_clk = ~sq_clk;

    osg_pulse_sequencer #(.CNT_W(CNT_W), .DEB_CYC(DEB), .MAX_LEN(MAXL)) dut (
        .sq_clk(sq_clk), .sq_rst(sq_rst), .btn_n(btn_n), .pc_start(pc_start),
        .end_flg(end_flg), .abort(abort), .pulse_len(pulse_len), .hold_len(hold_len),
`ifdef OSG_BURST_EN
        .burst_n(burst_n),
`endif
        .pulse_o(pulse_o), .busy(busy), .done(done), .timeout(timeout), .src(src)
    );

    typedef struct {
        int pulse_cyc;
        int busy_cyc;
        int npulse;
        int done;
        int tmo;
        int src;
    } exp_t;

    exp_t sb_q[$];
    int checks = 0;
    int failures = 0;

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Reference: build the busy-period timeline (1 = pulse high) from the rules.
    function automatic exp_t model(int len, int hold, int nb, int end_at, int abort_at, int s);
        exp_t e;
        bit tl[$];
        int lraw, l, h, n, tmo_at;
        bit wd, prev;
        lraw = (len == 0) ? int'(MAXL) : len;
        l    = (lraw < int'(MAXL)) ? lraw : int'(MAXL);
        wd   = (lraw >= int'(MAXL));
        h    = (hold == 0) ? 1 : hold;
        n    = (nb == 0) ? 1 : nb;
        tmo_at = 0;
        for (int k = 0; k < n; k++) begin
            int p = l;
            bit stop = 1'b0;
            if (k == 0 && end_at > 0 && end_at <= l) begin
                p = end_at; stop = 1'b1;
            end else if (wd) begin
                stop = 1'b1; tmo_at = tl.size() + l;
            end
            repeat (p) tl.push_back(1'b1);
            repeat (h) tl.push_back(1'b0);
            if (stop) break;
        end
        e.tmo  = (tmo_at != 0) ? 1 : 0;
        e.done = e.tmo ? 0 : 1;
        e.src  = s;
        if (abort_at > 0 && abort_at <= tl.size()) begin
            tl = tl[0:abort_at-1];
            e.done = 0;
            e.tmo  = (tmo_at != 0 && tmo_at < abort_at) ? 1 : 0;
        end
        e.busy_cyc = tl.size();
        e.pulse_cyc = 0;
        e.npulse = 0;
        prev = 1'b0;
        foreach (tl[i]) begin
            if (tl[i]) e.pulse_cyc++;
            if (tl[i] && !prev) e.npulse++;
            prev = tl[i];
        end
        return e;
    endfunction

    // Monitor: pops at busy rise, compares at busy fall.
    exp_t cur;
    bit   in_seq = 1'b0;
    bit   prev_p = 1'b0;
    int   bcnt = 0, pcnt = 0, npul = 0;

    always @(negedge sq_clk) begin
        if (sq_rst) begin
            in_seq = 1'b0;
        end else begin
            if (pulse_o && !busy) begin
                checks++; failures++;
                $display("FAIL pulse_without_busy actual=1 expected=0");
            end
            if (done && !(in_seq && !busy)) begin
                checks++; failures++;
                $display("FAIL stray_done actual=1 expected=0");
            end
            if (!in_seq && busy) begin
                if (sb_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_start actual=busy expected=idle");
                end else begin
                    cur = sb_q.pop_front();
                    chk("start_timeout_clr", int'(timeout), 0);
                    chk("start_src", int'(src), cur.src);
                end
                in_seq = 1'b1; bcnt = 0; pcnt = 0; npul = 0; prev_p = 1'b0;
            end
            if (in_seq && busy) begin
                bcnt++;
                if (pulse_o) pcnt++;
                if (pulse_o && !prev_p) npul++;
                prev_p = pulse_o;
                if (bcnt > 2000) begin
                    chk("busy_bound", bcnt, cur.busy_cyc);
                    in_seq = 1'b0;
                end
            end else if (in_seq && !busy) begin
                chk("pulse_cycles", pcnt, cur.pulse_cyc);
                chk("busy_cycles", bcnt, cur.busy_cyc);
                chk("pulse_count", npul, cur.npulse);
                chk("done", int'(done), cur.done);
                chk("timeout", int'(timeout), cur.tmo);
                chk("src", int'(src), cur.src);
                in_seq = 1'b0;
            end
        end
    end

    // kind: 0 = PC, 1 = button, 2 = button and PC in the same cycle
    task automatic run_seq(int kind, int len, int hold, int nb, int end_at, int abort_at, bit extra);
        exp_t e;
        int guard = 0;
        while (busy && guard < 3000) begin
            @(posedge sq_clk); #1;
            guard++;
        end
        chk("idle_before_start", int'(busy), 0);
        e = model(len, hold, BURST ? nb : 1, end_at, abort_at, (kind != 1) ? 1 : 0);
        sb_q.push_back(e);
        @(posedge sq_clk); #1;
        pulse_len = CNT_W'(len);
        hold_len  = CNT_W'(hold);
`ifdef OSG_BURST_EN
        burst_n = 8'(nb);
`endif
        if (kind != 0) begin
            btn_n = 1'b0;
            repeat (DEB + 2) @(posedge sq_clk);
            #1;
        end
        if (kind != 1) pc_start = 1'b1;
        @(posedge sq_clk); #1;
        for (int c = 1; c <= e.busy_cyc + 2; c++) begin
            end_flg = (c == end_at);
            abort   = (c == abort_at);
            if (c == 1) btn_n = 1'b1;
            if (c == 2) begin
                pc_start  = 1'b0;
                pulse_len = CNT_W'($urandom_range(1, 30));
                hold_len  = CNT_W'($urandom_range(0, 3));
            end
            if (extra && c == 3) pc_start = 1'b1;
            if (extra && c == 4) pc_start = 1'b0;
            @(posedge sq_clk); #1;
        end
        end_flg = 1'b0; abort = 1'b0; pc_start = 1'b0;
        if (kind != 0) repeat (DEB + 4) @(posedge sq_clk);
        #1;
    endtask

    initial begin
        int guard;
        #1 sq_rst = 1'b1;
        repeat (3) @(posedge sq_clk);
        #1;
        chk("rst_pulse_o", int'(pulse_o), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_timeout", int'(timeout), 0);
        chk("rst_src", int'(src), 0);
        sq_rst = 1'b0;
        repeat (3) @(posedge sq_clk);
        #1;

        run_seq(0, 10, 5, 1, 0, 0, 1'b0);
        // short button glitch must not start anything
        btn_n = 1'b0;
        repeat (DEB - 1) @(posedge sq_clk);
        #1 btn_n = 1'b1;
        repeat (2 * DEB + 4) @(posedge sq_clk);
        #1 chk("glitch_no_pulse", int'(busy), 0);
        run_seq(1, 6, 3, 1, 0, 0, 1'b0);
        run_seq(2, 7, 2, 1, 0, 0, 1'b1);
        run_seq(0, 0, 4, 1, 0, 0, 1'b0);
        chk("timeout_sticky", int'(timeout), 1);
        run_seq(0, 10, 3, 1, 3, 0, 1'b0);
        run_seq(0, 10, 3, 1, 0, 4, 1'b0);
        run_seq(0, 150, 0, 1, 0, 0, 1'b0);
        run_seq(0, 100, 2, 1, 100, 0, 1'b0);
`ifdef OSG_BURST_EN
        run_seq(0, 4, 2, 3, 0, 0, 1'b0);
        run_seq(0, 4, 2, 0, 0, 0, 1'b0);
`endif

        for (int i = 0; i < 30; i++) begin
            int kind, len, hold, nb, end_at, ab, l;
            bit extra;
            exp_t e0;
            kind = $urandom_range(0, 5);
            kind = (kind < 4) ? 0 : ((kind == 4) ? 1 : 2);
            case ($urandom_range(0, 7))
                0:       len = 0;
                1:       len = $urandom_range(101, 200);
                default: len = $urandom_range(1, 20);
            endcase
            hold = $urandom_range(0, 6);
            nb   = BURST ? $urandom_range(0, 3) : 1;
            l    = (len == 0 || len > int'(MAXL)) ? int'(MAXL) : len;
            end_at = ($urandom_range(0, 3) == 0) ? $urandom_range(1, l) : 0;
            e0 = model(len, hold, nb, end_at, 0, 0);
            ab = ($urandom_range(0, 4) == 0) ? $urandom_range(1, e0.busy_cyc) : 0;
            extra = (ab == 0 && (end_at == 0 || end_at >= 5) && l >= 5 && $urandom_range(0, 1) == 1);
            run_seq(kind, len, hold, nb, end_at, ab, extra);
        end

        guard = 0;
        while ((busy || sb_q.size() != 0) && guard < 3000) begin
            @(posedge sq_clk);
            guard++;
        end
        #1 chk("drain_queue", sb_q.size(), 0);

        // async reset mid-pulse
        sb_q.push_back(model(50, 0, 1, 0, 0, 1));
        @(posedge sq_clk); #1;
        pulse_len = CNT_W'(50);
        pc_start = 1'b1;
        @(posedge sq_clk); #1;
        pc_start = 1'b0;
        repeat (5) @(posedge sq_clk);
        #1 chk("pre_reset_pulse", int'(pulse_o), 1);
        #1 sq_rst = 1'b1;
        #1;
        chk("async_rst_pulse_o", int'(pulse_o), 0);
        chk("async_rst_busy", int'(busy), 0);
        chk("async_rst_src", int'(src), 0);
        chk("async_rst_timeout", int'(timeout), 0);
        @(posedge sq_clk); #1;
        sq_rst = 1'b0;
        repeat (4) @(posedge sq_clk);
        #1 chk("post_reset_idle", int'(busy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
